// File: rtl/gost_sbox_pkg.sv
// Shared constants and state encoding for the GOST 28147-89 S-box controller.
package gost_sbox_pkg;

    localparam int ROWS         = 16;
    localparam int ROW_W        = 4;
    localparam int NBOX_DEFAULT = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_e;

endpackage

// File: rtl/ram16x4bit.sv
// 16x4 single-port RAM primitive: CEN=1 enables access, WEN=1 writes D, WEN=0 reads into Q.
module ram16x4bit (
    input  logic       CLK,
    input  logic       CEN,
    input  logic       WEN,
    input  logic [3:0] A,
    input  logic [3:0] D,
    output logic [3:0] Q
);

    logic [3:0] mem_q [16];

    // NOTE: storage arrays carry no reset; contents are defined only by writes.
    always_ff @(posedge CLK) begin
        if (CEN) begin
            if (WEN) begin
                mem_q[A] <= D;
            end else begin
                Q <= mem_q[A];
            end
        end
    end

endmodule

// File: rtl/gost_sbox_ctrl.sv
// GOST S-box controller: sequences 16-row table loads and 1-cycle pipelined lookups
// over NBOX ram16x4bit instances. Optional lock feature: define GOST_SBOX_LOCK_EN.
module gost_sbox_ctrl
    import gost_sbox_pkg::*;
#(
    parameter int NBOX = NBOX_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST_N,
`ifdef GOST_SBOX_LOCK_EN
    input  logic              lock,
`endif
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [4*NBOX-1:0] load_data,
    output logic              load_ready,
    input  logic              sub_valid,
    input  logic [4*NBOX-1:0] sub_in,
    output logic              sub_ready,
    output logic              out_valid,
    output logic [4*NBOX-1:0] sub_out,
    output logic              loaded,
    output logic              busy
);

    localparam int W = 4 * NBOX;

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             out_valid_q;
    logic             start_eff;
    logic             wr_fire;
    logic             rd_fire;
    logic             ram_cen;
    logic [W-1:0]     ram_q;

`ifdef GOST_SBOX_LOCK_EN
    logic locked_q, locked_d;

    // Once locked, the table is frozen until reset and lookups never stall.
    assign start_eff = load_start & ~locked_q;
`else
    assign start_eff = load_start;
`endif

    assign load_ready = (state_q == LOAD)  & ~start_eff;
    assign sub_ready  = (state_q == READY) & ~start_eff;
    assign wr_fire    = load_valid & load_ready;
    assign rd_fire    = sub_valid & sub_ready;
    assign ram_cen    = wr_fire | rd_fire;

    assign loaded    = (state_q == READY);
    assign busy      = (state_q == LOAD);
    assign out_valid = out_valid_q;
    assign sub_out   = out_valid_q ? ram_q : '0;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
`ifdef GOST_SBOX_LOCK_EN
        locked_d = locked_q | ((state_q == READY) & lock);
`endif
        if (start_eff) begin
            state_d = LOAD;
            row_d   = '0;
        end else if (state_q == LOAD && wr_fire) begin
            row_d = row_q + 1'b1;
            if (row_q == ROW_W'(ROWS - 1)) begin
                state_d = READY;
            end
        end
    end

    // NOTE: synchronous reset; sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= EMPTY;
            row_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef GOST_SBOX_LOCK_EN
            locked_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            out_valid_q <= rd_fire;
`ifdef GOST_SBOX_LOCK_EN
            locked_q    <= locked_d;
`endif
        end
    end

    // Writes address by row counter; lookups address each box by its own nibble.
    for (genvar g = 0; g < NBOX; g++) begin : g_box
        ram16x4bit u_box (
            .CLK (CLK),
            .CEN (ram_cen),
            .WEN (wr_fire),
            .A   (wr_fire ? row_q : sub_in[4*g +: 4]),
            .D   (load_data[4*g +: 4]),
            .Q   (ram_q[4*g +: 4])
        );
    end

endmodule

// File: tb/tb_gost_sbox_ctrl.sv
// Self-checking bench for gost_sbox_ctrl: table-driven lookups with a scoreboard queue.
module tb_gost_sbox_ctrl;

    typedef logic [31:0] table_t [16];

    typedef struct {
        logic [31:0] in;
        logic [31:0] exp;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        sub_valid = 1'b0;
    logic [31:0] sub_in = '0;
`ifdef GOST_SBOX_LOCK_EN
    logic        lock = 1'b0;
`endif
    logic        load_ready;
    logic        sub_ready;
    logic        out_valid;
    logic [31:0] sub_out;
    logic        loaded;
    logic        busy;

    gost_sbox_ctrl #(.NBOX(8)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
`ifdef GOST_SBOX_LOCK_EN
        .lock       (lock),
`endif
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .sub_valid  (sub_valid),
        .sub_in     (sub_in),
        .sub_ready  (sub_ready),
        .out_valid  (out_valid),
        .sub_out    (sub_out),
        .loaded     (loaded),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Scoreboard: every out_valid pulse must match the oldest pending expectation.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("out_valid_spurious", {31'b0, out_valid}, 32'd0);
                end else begin
                    check("sub_out", sub_out, exp_q.pop_front());
                end
            end else begin
                check("sub_out_gated", sub_out, 32'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N      = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        sub_valid  = 1'b0;
`ifdef GOST_SBOX_LOCK_EN
        lock       = 1'b0;
`endif
        cyc();
        cyc();
        exp_q.delete();
        check("rst_load_ready", {31'b0, load_ready}, 32'd0);
        check("rst_sub_ready",  {31'b0, sub_ready},  32'd0);
        check("rst_out_valid",  {31'b0, out_valid},  32'd0);
        check("rst_sub_out",    sub_out,             32'd0);
        check("rst_loaded",     {31'b0, loaded},     32'd0);
        check("rst_busy",       {31'b0, busy},       32'd0);
        RST_N = 1'b1;
    endtask

    // Loads 16 rows; gaps inserts an idle cycle before each beat; abort_at restarts once.
    task automatic load_table(input table_t rows, input bit gaps, input int abort_at);
        bit aborted = 1'b0;
        load_start = 1'b1;
        #1;
        check("load_ready_on_start", {31'b0, load_ready}, 32'd0);
        cyc();
        load_start = 1'b0;
        for (int r = 0; r < 16; r++) begin
            if (!aborted && r == abort_at) begin
                aborted    = 1'b1;
                load_valid = 1'b0;
                load_start = 1'b1;
                cyc();
                load_start = 1'b0;
                check("restart_busy",   {31'b0, busy},   32'd1);
                check("restart_loaded", {31'b0, loaded}, 32'd0);
                r = -1;
                continue;
            end
            if (gaps) begin
                load_valid = 1'b0;
                cyc();
                check("gap_busy", {31'b0, busy}, 32'd1);
            end
            load_valid = 1'b1;
            load_data  = rows[r];
            #1;
            check("load_ready", {31'b0, load_ready}, 32'd1);
            check("load_busy",  {31'b0, busy},       32'd1);
            cyc();
            if (r < 15) check("loaded_early", {31'b0, loaded}, 32'd0);
        end
        load_valid = 1'b0;
        check("loaded_done", {31'b0, loaded}, 32'd1);
        check("busy_done",   {31'b0, busy},   32'd0);
    endtask

    task automatic lookup(input logic [31:0] in, input logic [31:0] exp, input bit accept);
        sub_valid = 1'b1;
        sub_in    = in;
        #1;
        check("sub_ready", {31'b0, sub_ready}, {31'b0, accept});
        if (accept) exp_q.push_back(exp);
        cyc();
        sub_valid = 1'b0;
    endtask

    initial begin
        table_t id_t;
        table_t inv_t;
        vec_t   id_vecs  [2];
        vec_t   inv_vecs [3];
        for (int r = 0; r < 16; r++) begin
            logic [3:0] n;
            n        = 4'(r);
            id_t[r]  = {8{n}};
            inv_t[r] = {8{~n}};
        end
        id_vecs[0]  = '{in: 32'h76543210, exp: 32'h76543210};
        id_vecs[1]  = '{in: 32'hFEDCBA98, exp: 32'hFEDCBA98};
        inv_vecs[0] = '{in: 32'h0000000F, exp: 32'hFFFFFFF0};
        inv_vecs[1] = '{in: 32'h12345678, exp: 32'hEDCBA987};
        inv_vecs[2] = '{in: 32'h76543210, exp: 32'h89ABCDEF};

        do_reset();

        // EMPTY: lookups refused, load beats ignored
        lookup(32'h00000001, 32'h0, 1'b0);
        load_valid = 1'b1;
        cyc();
        load_valid = 1'b0;
        check("empty_ignores_load", {31'b0, busy}, 32'd0);

        // Identity table, back-to-back lookups
        load_table(id_t, 1'b0, -1);
        for (int i = 0; i < 2; i++) begin
            sub_valid = 1'b1;
            sub_in    = id_vecs[i].in;
            #1;
            check("id_sub_ready", {31'b0, sub_ready}, 32'd1);
            exp_q.push_back(id_vecs[i].exp);
            cyc();
        end
        sub_valid = 1'b0;
        cyc();
        cyc();

        // Inverted table loaded with gaps, back-to-back lookups
        load_table(inv_t, 1'b1, -1);
        for (int i = 0; i < 3; i++) begin
            sub_valid = 1'b1;
            sub_in    = inv_vecs[i].in;
            #1;
            check("inv_sub_ready", {31'b0, sub_ready}, 32'd1);
            exp_q.push_back(inv_vecs[i].exp);
            cyc();
        end
        sub_valid = 1'b0;
        cyc();

        // load_valid in READY must not disturb the table
        load_valid = 1'b1;
        load_data  = 32'h0;
        cyc();
        load_valid = 1'b0;
        lookup(32'h12345678, 32'hEDCBA987, 1'b1);
        cyc();

        // Lookup then load_start with a colliding lookup: old-table result still emerges
        lookup(32'h0000000F, 32'hFFFFFFF0, 1'b1);
        load_start = 1'b1;
        sub_valid  = 1'b1;
        sub_in     = 32'h12345678;
        #1;
        check("collide_sub_ready", {31'b0, sub_ready}, 32'd0);
        cyc();
        load_start = 1'b0;
        sub_valid  = 1'b0;
        check("collide_busy",   {31'b0, busy},   32'd1);
        check("collide_loaded", {31'b0, loaded}, 32'd0);
        cyc();
        check("collide_drained", exp_q.size(), 32'd0);

        // Restart mid-load at row 7, then verify identity contents
        load_table(id_t, 1'b0, 7);
        lookup(32'h76543210, 32'h76543210, 1'b1);
        lookup(32'h0F1E2D3C, 32'h0F1E2D3C, 1'b1);
        cyc();

`ifdef GOST_SBOX_LOCK_EN
        lock = 1'b1;
        cyc();
        lock       = 1'b0;
        load_start = 1'b1;
        lookup(32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1);
        load_start = 1'b0;
        check("lock_busy",   {31'b0, busy},   32'd0);
        check("lock_loaded", {31'b0, loaded}, 32'd1);
        lookup(32'h13579BDF, 32'h13579BDF, 1'b1);
        cyc();
        check("lock_drained", exp_q.size(), 32'd0);
        do_reset();
        load_table(id_t, 1'b0, -1);
`endif

        // Reset while a lookup is presented: nothing may emerge afterwards
        check("pre_reset_drained", exp_q.size(), 32'd0);
        sub_valid = 1'b1;
        sub_in    = 32'h11111111;
        RST_N     = 1'b0;
        cyc();
        sub_valid = 1'b0;
        check("rstmid_out_valid", {31'b0, out_valid}, 32'd0);
        check("rstmid_loaded",    {31'b0, loaded},    32'd0);
        RST_N = 1'b1;
        cyc();
        cyc();
        check("final_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
